// File: rtl/resp_pkg.sv
// Shared types and constants for the 65C02 bus responder.
package resp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXT  = 1'b1
    } state_e;

    typedef enum logic {
        DI_SEL_RAM  = 1'b0,
        DI_SEL_HOLD = 1'b1
    } di_sel_e;

    localparam logic [7:0]  ABORT_RDATA = 8'hFF;
    localparam int unsigned CNT_W       = 8;

    // True when the address falls inside the zero-wait-state window.
    function automatic logic is_fast(input logic [15:0] addr, input int unsigned aw);
        return (addr >> aw) == 16'd0;
    endfunction

endpackage

// File: rtl/bus_responder_fast_ram.sv
// Single-port synchronous RAM backing the fast window; contents are not reset.
module fast_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 65C02 bus: fast on-chip window plus stalled external port.
// Optional access timeout with sticky bus_err is enabled by defining RESP_TIMEOUT_EN.
module bus_responder
    import resp_pkg::*;
#(
    parameter int unsigned FAST_AW = 12,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic        bus_err
);

    state_e      state_q, state_d;
    di_sel_e     di_sel_q, di_sel_d;
    logic        rdy_q, rdy_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [15:0] ext_addr_q, ext_addr_d;
    logic [7:0]  ext_wdata_q, ext_wdata_d;
    logic [7:0]  hold_q, hold_d;

    logic        fast_hit_c;
    logic        ack_c;
    logic        expire_c;
    logic        ram_we_c;
    logic [7:0]  ram_rdata_c;
    logic [7:0]  di_c;

    assign fast_hit_c = is_fast(AB, FAST_AW);
    assign ack_c      = ext_req_q && ext_ack;
    assign ram_we_c   = (state_q == ST_IDLE) && fast_hit_c && WE;
    assign di_c       = (di_sel_q == DI_SEL_RAM) ? ram_rdata_c : hold_q;

    fast_ram #(.AW(FAST_AW)) u_fast_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (AB[FAST_AW-1:0]),
        .wdata (DO),
        .rdata (ram_rdata_c)
    );

`ifdef RESP_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    // Ack in the expiry cycle takes priority over the abort.
    assign expire_c = (state_q == ST_EXT) && !ack_c && (cnt_q == TIMEOUT - 8'd1);

    always_comb begin
        cnt_d     = (state_q == ST_EXT) ? cnt_q + CNT_W'(1) : '0;
        bus_err_d = bus_err_q | expire_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_timeout_c;

    assign expire_c         = 1'b0;
    assign bus_err          = 1'b0;
    assign unused_timeout_c = ^{TIMEOUT, CNT_W[7:0]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fast_hit_c) state_d = ST_EXT;
            ST_EXT:  if (ack_c || expire_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Writes freeze DI by copying the visible value into the hold register.
    always_comb begin
        rdy_d       = (state_d == ST_IDLE);
        ext_req_d   = (state_d == ST_EXT);
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        hold_d      = hold_q;
        di_sel_d    = di_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (WE) begin
                    hold_d   = di_c;
                    di_sel_d = DI_SEL_HOLD;
                end else begin
                    di_sel_d = fast_hit_c ? DI_SEL_RAM : DI_SEL_HOLD;
                end
                if (!fast_hit_c) begin
                    ext_addr_d  = AB;
                    ext_we_d    = WE;
                    ext_wdata_d = DO;
                end
            end
            ST_EXT: begin
                if (ack_c && !ext_we_q) begin
                    hold_d = ext_rdata;
                end else if (expire_c && !ext_we_q) begin
                    hold_d = ABORT_RDATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q       <= 1'b1;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            hold_q      <= '0;
            di_sel_q    <= DI_SEL_HOLD;
        end else begin
            rdy_q       <= rdy_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            hold_q      <= hold_d;
            di_sel_q    <= di_sel_d;
        end
    end

    assign DI        = di_c;
    assign RDY       = rdy_q;
    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed plus randomized bench for bus_responder against an array-based memory model.
module tb_bus_responder;

    localparam int unsigned FAST_AW = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic        WE;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        RDY;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        ext_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];
    logic [7:0] exp_di;

    always #5 clk = ~clk;

    bus_responder #(.FAST_AW(FAST_AW), .TIMEOUT(8'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .AB        (AB),
        .WE        (WE),
        .DO        (DO),
        .DI        (DI),
        .RDY       (RDY),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .bus_err   (bus_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_core();
        AB = 16'($urandom);
        WE = 1'($urandom);
        DO = 8'($urandom);
    endtask

    // One core access; external ones are acked dly cycles after the first stall cycle.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input int dly, input logic [7:0] rd);
        AB = a;
        WE = w;
        DO = d;
        if (int'(a) < (1 << FAST_AW)) begin
            ext_ack   = 1'($urandom);
            ext_rdata = 8'($urandom);
            cyc();
            ext_ack = 1'b0;
            if (w) mem[a[11:0]] = d;
            else   exp_di = mem[a[11:0]];
            chk("fast_rdy", RDY, 16'd1);
            chk("fast_di", DI, exp_di);
            chk("fast_req", ext_req, 16'd0);
        end else begin
            cyc();
            chk("ext_rdy", RDY, 16'd0);
            chk("ext_req", ext_req, 16'd1);
            chk("ext_addr", ext_addr, a);
            chk("ext_we", ext_we, w);
            if (w) chk("ext_wdata", ext_wdata, d);
            scramble_core();
            for (int i = 0; i < dly; i++) begin
                cyc();
                chk("stall_rdy", RDY, 16'd0);
                chk("stall_addr", ext_addr, a);
                scramble_core();
            end
            ext_ack   = 1'b1;
            ext_rdata = rd;
            cyc();
            ext_ack = 1'b0;
            if (!w) exp_di = rd;
            chk("done_rdy", RDY, 16'd1);
            chk("done_req", ext_req, 16'd0);
            chk("done_di", DI, exp_di);
        end
    endtask

    initial begin
        reset     = 1'b1;
        AB        = '0;
        WE        = 1'b0;
        DO        = '0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        exp_di    = 8'h00;
        cyc();
        cyc();
        chk("rst_rdy", RDY, 16'd1);
        chk("rst_di", DI, 16'h00);
        chk("rst_req", ext_req, 16'd0);
        chk("rst_we", ext_we, 16'd0);
        chk("rst_addr", ext_addr, 16'h0000);
        chk("rst_wdata", ext_wdata, 16'h00);
        chk("rst_err", bus_err, 16'd0);
        reset = 1'b0;

        // Directed scenarios
        access(16'h0123, 1'b1, 8'h5A, 0, 8'h00);
        access(16'h0123, 1'b0, 8'h00, 0, 8'h00);
        chk("fast_rd_5a", DI, 16'h5A);
        access(16'h8000, 1'b0, 8'h00, 2, 8'hC3);
        chk("ext_rd_c3", DI, 16'hC3);
        access(16'hD000, 1'b1, 8'h77, 0, 8'hEE);
        chk("ext_wr_holds_di", DI, 16'hC3);
        access(16'h0FFF, 1'b1, 8'hA5, 0, 8'h00);
        access(16'h1000, 1'b0, 8'h00, 1, 8'h3E);
        access(16'h0FFF, 1'b0, 8'h00, 0, 8'h00);
        chk("edge_fast_rd", DI, 16'hA5);

        // Reset in the middle of an external access, then a late ack
        AB = 16'h8100;
        WE = 1'b0;
        cyc();
        chk("midext_req", ext_req, 16'd1);
        reset = 1'b1;
        cyc();
        exp_di = 8'h00;
        chk("midrst_req", ext_req, 16'd0);
        chk("midrst_rdy", RDY, 16'd1);
        chk("midrst_di", DI, 16'h00);
        reset     = 1'b0;
        ext_ack   = 1'b1;
        ext_rdata = 8'h99;
        AB        = 16'h0200;
        WE        = 1'b1;
        DO        = 8'h11;
        cyc();
        ext_ack = 1'b0;
        mem[12'h200] = 8'h11;
        chk("late_ack_rdy", RDY, 16'd1);
        chk("late_ack_req", ext_req, 16'd0);
        chk("late_ack_di", DI, 16'h00);

        // Populate a small fast region so random reads have known contents
        for (int i = 0; i < 64; i++) access(16'(i), 1'b1, 8'($urandom), 0, 8'h00);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 63));
            else                           a = 16'($urandom_range(16'h1000, 16'hFFFF));
            access(a, 1'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 8'($urandom));
        end
        chk("err_quiet", bus_err, 16'd0);

`ifdef RESP_TIMEOUT_EN
        // No ack: abort after four EXT cycles
        AB = 16'h9000;
        WE = 1'b0;
        cyc();
        chk("to_req", ext_req, 16'd1);
        for (int i = 0; i < 3; i++) begin
            scramble_core();
            cyc();
            chk("to_stall_rdy", RDY, 16'd0);
        end
        scramble_core();
        cyc();
        exp_di = 8'hFF;
        chk("to_rdy", RDY, 16'd1);
        chk("to_req_low", ext_req, 16'd0);
        chk("to_di", DI, 16'hFF);
        chk("to_err", bus_err, 16'd1);
        access(16'h0005, 1'b0, 8'h00, 0, 8'h00);
        access(16'hA000, 1'b0, 8'h00, 1, 8'h42);
        chk("to_err_sticky", bus_err, 16'd1);
        reset = 1'b1;
        cyc();
        reset  = 1'b0;
        exp_di = 8'h00;
        chk("to_err_clr", bus_err, 16'd0);
        // Ack arriving in the expiry cycle wins
        access(16'h9000, 1'b0, 8'h00, 3, 8'h3C);
        chk("to_ack_wins_di", DI, 16'h3C);
        chk("to_ack_wins_err", bus_err, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
